// File: rtl/tinyvga_monitor.sv
// tinyvga_monitor: measures Tiny VGA sync timing and locks on stable frames.
// Ports: clk, rst, vga_in[7:0] in; locked, frame_pulse, h_period, h_sync_w,
// v_lines, v_sync_w, frame_cnt, err_cnt, frame_sig out.
// Optional CRC-16 frame signature: define TINYVGA_MONITOR_SIG_EN.
module tinyvga_monitor #(
  parameter int H_POL_N   = 1,
  parameter int V_POL_N   = 1,
  parameter int TIMEOUT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vga_in,
  output logic        locked,
  output logic        frame_pulse,
  output logic [11:0] h_period,
  output logic [11:0] h_sync_w,
  output logic [10:0] v_lines,
  output logic [10:0] v_sync_w,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt,
  output logic [15:0] frame_sig
);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [TIMEOUT_W-1:0] TO_ONE = 1;

  state_t state, state_nx;

  logic hs_a, vs_a;
  logic s1_h, s2_h, s1_v, s2_v;
  logic h_edge, h_trail, v_edge;

  logic [11:0] h_cnt, hs_cnt;
  logic [11:0] sh_h_period, sh_h_sync_w;
  logic [10:0] v_cnt, vs_cnt;
  logic [TIMEOUT_W-1:0] to_cnt;

  logic timeout, h_bad, v_bad, match;
  logic upd, upd_q, ref_ok, dirty;

  assign hs_a = (H_POL_N != 0) ? ~vga_in[7] : vga_in[7];
  assign vs_a = (V_POL_N != 0) ? ~vga_in[3] : vga_in[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_h <= 1'b0;
      s2_h <= 1'b0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_h <= hs_a;
      s2_h <= s1_h;
      s1_v <= vs_a;
      s2_v <= s1_v;
    end
  end

  assign h_edge  = s1_h & ~s2_h;
  assign h_trail = ~s1_h & s2_h;
  assign v_edge  = s1_v & ~s2_v;

  // h_edge already restarts the count, so it never times out.
  assign timeout = (to_cnt == '1) && !h_edge;
  assign h_bad   = h_edge && (h_cnt != h_period);
  assign v_bad   = v_edge && (v_cnt != v_lines);
  assign match   = (sh_h_period == h_period) &&
                   (v_cnt == v_lines);
  assign upd     = v_edge && (state != SEARCH) && !timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      hs_cnt      <= '0;
      sh_h_period <= '0;
      sh_h_sync_w <= '0;
      v_cnt       <= '0;
      vs_cnt      <= '0;
      to_cnt      <= '0;
    end else begin
      if (h_edge)
        h_cnt <= 12'd1;
      else if (h_cnt != 12'hFFF)
        h_cnt <= h_cnt + 12'd1;
      if (h_edge)
        sh_h_period <= h_cnt;
      if (h_edge)
        hs_cnt <= 12'd1;
      else if (s1_h && hs_cnt != 12'hFFF)
        hs_cnt <= hs_cnt + 12'd1;
      if (h_trail)
        sh_h_sync_w <= hs_cnt;
      // A line starting with the frame belongs to it.
      if (v_edge)
        v_cnt <= h_edge ? 11'd1 : 11'd0;
      else if (h_edge && v_cnt != 11'h7FF)
        v_cnt <= v_cnt + 11'd1;
      if (v_edge)
        vs_cnt <= h_edge ? 11'd1 : 11'd0;
      else if (h_edge && s1_v && vs_cnt != 11'h7FF)
        vs_cnt <= vs_cnt + 11'd1;
      if (h_edge)
        to_cnt <= '0;
      else if (to_cnt != '1)
        to_cnt <= to_cnt + TO_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= SEARCH;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      SEARCH:  if (v_edge) state_nx = MEASURE;
      MEASURE: if (v_edge && ref_ok && match)
                 state_nx = LOCKED;
      LOCKED:  if (h_bad || v_bad) state_nx = MEASURE;
      default: state_nx = SEARCH;
    endcase
    if (timeout)
      state_nx = SEARCH;
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  // ref_ok: previous frame is a clean reference for lock.
  // dirty: current frame was broken mid-way, not a reference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_period    <= '0;
      h_sync_w    <= '0;
      v_lines     <= '0;
      v_sync_w    <= '0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
      upd_q       <= 1'b0;
      frame_pulse <= 1'b0;
      ref_ok      <= 1'b0;
      dirty       <= 1'b0;
    end else begin
      upd_q       <= upd;
      frame_pulse <= upd_q;
      if (upd) begin
        h_period  <= sh_h_period;
        h_sync_w  <= sh_h_sync_w;
        v_lines   <= v_cnt;
        v_sync_w  <= vs_cnt;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (state == LOCKED && state_nx == MEASURE) begin
        if (err_cnt != 8'hFF)
          err_cnt <= err_cnt + 8'd1;
        ref_ok <= 1'b0;
        dirty  <= !v_edge;
      end else if (state == SEARCH &&
                   state_nx == MEASURE) begin
        ref_ok <= 1'b0;
        dirty  <= 1'b0;
      end else if (state == MEASURE && upd) begin
        ref_ok <= !dirty;
        dirty  <= 1'b0;
      end
    end
  end

`ifdef TINYVGA_MONITOR_SIG_EN
  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic [5:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 5; i >= 0; i--) begin
      if (r[15] ^ d[i])
        r = {r[14:0], 1'b0} ^ 16'h1021;
      else
        r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  logic [5:0]  s1_col;
  logic [15:0] crc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_col    <= '0;
      crc_q     <= 16'hFFFF;
      frame_sig <= '0;
    end else begin
      s1_col <= {vga_in[0], vga_in[4], vga_in[1],
                 vga_in[5], vga_in[2], vga_in[6]};
      if (v_edge)
        crc_q <= crc_step(16'hFFFF, s1_col);
      else
        crc_q <= crc_step(crc_q, s1_col);
      if (upd)
        frame_sig <= crc_q;
    end
  end
`else
  logic unused_col;
  assign unused_col = ^{vga_in[6:4], vga_in[2:0]};
  assign frame_sig  = '0;
`endif

endmodule

// File: tb/tb_tinyvga_monitor.sv
// tb_tinyvga_monitor: directed bench for tinyvga_monitor.
// 20 clk/line, HSYNC 4, 10 lines, VSYNC 2 lines, active-low syncs.
module tb_tinyvga_monitor;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  vga_in;
  logic        locked;
  logic        frame_pulse;
  logic [11:0] h_period;
  logic [11:0] h_sync_w;
  logic [10:0] v_lines;
  logic [10:0] v_sync_w;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
  logic [15:0] frame_sig;

  tinyvga_monitor #(
    .H_POL_N(1),
    .V_POL_N(1),
    .TIMEOUT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga_in(vga_in),
    .locked(locked),
    .frame_pulse(frame_pulse),
    .h_period(h_period),
    .h_sync_w(h_sync_w),
    .v_lines(v_lines),
    .v_sync_w(v_sync_w),
    .frame_cnt(frame_cnt),
    .err_cnt(err_cnt),
    .frame_sig(frame_sig)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          f;
    logic        lk;
    logic        fp;
    logic [11:0] hp;
    logic [11:0] hw;
    logic [10:0] vl;
    logic [10:0] vw;
    logic [15:0] fc;
    logic [7:0]  ec;
    int          nsym;
  } vec_t;

  vec_t tbl[9];
  vec_t v;

  int checks = 0;
  int errors = 0;
  int frm, line, col, stretch_line;

  function automatic logic [15:0] ref_crc(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 0; k < n * 6; k++) begin
      fb = c[15];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  function automatic logic [15:0] exp_sig(input int n);
`ifdef TINYVGA_MONITOR_SIG_EN
    return (n == 0) ? 16'h0000 : ref_crc(n);
`else
    return (n < 0) ? ref_crc(0) : 16'h0000;
`endif
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic check_row(input vec_t r, input string tag);
    chk({tag, " locked"}, 32'(locked), 32'(r.lk));
    chk({tag, " frame_pulse"}, 32'(frame_pulse), 32'(r.fp));
    chk({tag, " h_period"}, 32'(h_period), 32'(r.hp));
    chk({tag, " h_sync_w"}, 32'(h_sync_w), 32'(r.hw));
    chk({tag, " v_lines"}, 32'(v_lines), 32'(r.vl));
    chk({tag, " v_sync_w"}, 32'(v_sync_w), 32'(r.vw));
    chk({tag, " frame_cnt"}, 32'(frame_cnt), 32'(r.fc));
    chk({tag, " err_cnt"}, 32'(err_cnt), 32'(r.ec));
    chk({tag, " frame_sig"}, 32'(frame_sig),
        32'(exp_sig(r.nsym)));
  endtask

  function automatic logic [7:0] gen();
    logic hs, vs;
    hs = (col < 4);
    vs = (line < 2);
    return {~hs, 3'b000, ~vs, 3'b000};
  endfunction

  task automatic step();
    vga_in = gen();
    @(posedge clk);
    #1;
    col++;
    if (col == ((line == stretch_line) ? 21 : 20)) begin
      col = 0;
      line++;
      if (line == 10) begin
        line = 0;
        frm++;
      end
    end
  endtask

  task automatic run_to(input int f, input int l,
                        input int c);
    int guard;
    guard = 0;
    while (!(frm == f && line == l && col == c)) begin
      step();
      guard++;
      if (guard > 3000) begin
        checks++;
        errors++;
        $display("FAIL run_to bound f%0d l%0d c%0d",
                 f, l, c);
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      vga_in = 8'h88;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t z, g;
    z = '{0, 1'b0, 1'b0, 12'd0, 12'd0, 11'd0, 11'd0,
          16'd0, 8'd0, 0};
    g = '{0, 1'b0, 1'b1, 12'd20, 12'd4, 11'd10, 11'd2,
          16'd0, 8'd0, 200};

    tbl[0] = z;
    for (int i = 1; i < 9; i++) begin
      tbl[i]    = g;
      tbl[i].f  = i;
      tbl[i].fc = 16'(i);
    end
    tbl[2].lk = 1'b1;
    tbl[3].lk = 1'b1;
    tbl[4].lk = 1'b1;
    tbl[5].lk = 1'b1;
    tbl[6].ec = 8'd1;
    tbl[6].nsym = 201;
    tbl[7].ec = 8'd1;
    tbl[8].ec = 8'd1;
    tbl[8].lk = 1'b1;

    frm = 0;
    line = 0;
    col = 0;
    stretch_line = -1;
    rst = 1'b1;
    vga_in = 8'h88;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_row(z, "reset");
    rst = 1'b0;
    idle(3);

    for (int i = 0; i < 6; i++) begin
      run_to(tbl[i].f, 0, 3);
      check_row(tbl[i], $sformatf("frame%0d", tbl[i].f));
    end

    stretch_line = 4;
    run_to(5, 4, 20);
    chk("pre-stretch locked", 32'(locked), 32'd1);
    run_to(5, 5, 3);
    chk("stretch locked", 32'(locked), 32'd0);
    chk("stretch err_cnt", 32'(err_cnt), 32'd1);
    stretch_line = -1;

    for (int i = 6; i < 9; i++) begin
      run_to(tbl[i].f, 0, 3);
      check_row(tbl[i], $sformatf("frame%0d", tbl[i].f));
    end

    run_to(9, 0, 2);
    chk("latency pulse early", 32'(frame_pulse), 32'd0);
    step();
    chk("latency pulse", 32'(frame_pulse), 32'd1);
    step();
    chk("latency pulse width", 32'(frame_pulse), 32'd0);

    idle(244);
    chk("pre-timeout locked", 32'(locked), 32'd1);
    idle(14);
    v = g;
    v.fp = 1'b0;
    v.fc = 16'd9;
    v.ec = 8'd1;
    check_row(v, "timeout");

    frm = 10;
    line = 0;
    col = 0;
    run_to(11, 0, 3);
    v = g;
    v.fc = 16'd10;
    v.ec = 8'd1;
    check_row(v, "retry");
    run_to(12, 0, 3);
    v.lk = 1'b1;
    v.fc = 16'd11;
    check_row(v, "relock");

    run_to(12, 5, 7);
    rst = 1'b1;
    #1;
    check_row(z, "midrst");
    step();
    step();
    rst = 1'b0;
    run_to(13, 0, 3);
    check_row(z, "postrst v1");
    run_to(14, 0, 3);
    v = g;
    v.fc = 16'd1;
    check_row(v, "postrst v2");
    run_to(15, 0, 3);
    v.lk = 1'b1;
    v.fc = 16'd2;
    check_row(v, "postrst lock");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
